pipe_mult_csa: RTL and testbench

Parametrised pipelined W×W multiplier with carry-save (Wallace) reduction, per-transaction signed/unsigned mode, a sideband tag, and valid/ready flow control on both sides. It is the general-width, back-pressurable successor to the fixed 8×8 free-running multiplier. It sits between a producer stream and a consumer stream in the datapath. Latency is fixed at 4 cycles when the pipeline is not stalled.

---
 rtl/pipe_mult_csa.sv | 194 +++++++++++++++++++
 tb/tb_pipe_mult_csa.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mult_csa.sv
// Pipelined WxW multiplier: Baugh-Wooley partial products, Wallace CSA reduction, valid/ready flow control.
// Optional accumulate stage compiled in with `define PIPE_MULT_ACC_EN (adds the in_acc port).
module pipe_mult_csa #(
    parameter int W     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sgn,
    input  logic [TAG_W-1:0] in_tag,
`ifdef PIPE_MULT_ACC_EN
    input  logic             in_acc,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic [TAG_W-1:0] out_tag
);

    typedef logic [W-1:0][2*W-1:0] rows_t;

    function automatic int unsigned next_rows(input int unsigned n);
        return (n > 2) ? 2 * (n / 3) + n % 3 : n;
    endfunction

    function automatic int unsigned tree_levels(input int unsigned n);
        int unsigned k = n;
        int unsigned l = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (k > 2) begin
                k = next_rows(k);
                l = l + 1;
            end
        end
        return l;
    endfunction

    function automatic int unsigned rows_after(input int unsigned n, input int unsigned lv);
        int unsigned k = n;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < lv) k = next_rows(k);
        end
        return k;
    endfunction

    // One Wallace level: every full group of three rows becomes sum + shifted carry.
    function automatic rows_t csa_level(input rows_t r, input int unsigned n);
        rows_t       o;
        int unsigned m;
        o = '0;
        m = 0;
        for (int unsigned g = 0; g < W / 3; g++) begin
            if (g < n / 3) begin
                o[m]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
                o[m+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
                m = m + 2;
            end
        end
        for (int unsigned k = 0; k < 2; k++) begin
            if (k < n % 3) begin
                o[m] = r[3*(n/3)+k];
                m = m + 1;
            end
        end
        return o;
    endfunction

    function automatic rows_t csa_reduce(input rows_t r, input int unsigned n, input int unsigned lv);
        rows_t       t = r;
        int unsigned k = n;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < lv) begin
                t = csa_level(t, k);
                k = next_rows(k);
            end
        end
        return t;
    endfunction

    function automatic logic [4*W-1:0] csa_pair(input rows_t r, input int unsigned n, input int unsigned lv);
        rows_t t = csa_reduce(r, n, lv);
        return {t[1], t[0]};
    endfunction

    localparam int unsigned LVLS  = tree_levels(W);
    localparam int unsigned LV_A  = (LVLS + 1) / 2;
    localparam int unsigned LV_B  = LVLS - LV_A;
    localparam int unsigned N_MID = rows_after(W, LV_A);

    logic             adv;
    logic             s1_v, s2_v, s3a_v, s3b_v;
    logic [W-1:0]     s1_a, s1_b;
    logic             s1_sgn;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3a_tag, s3b_tag;
    rows_t            pp, s2_pp, tree_a, s3a_rows;
    logic [2*W-1:0]   sum_d, carry_d, s3b_sum, s3b_carry;
    logic [2*W-1:0]   prod, res;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Signed rows invert only the terms where exactly one operand bit is the MSB.
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < W; i++) begin
            for (int unsigned j = 0; j < W; j++) begin
                pp[i][i+j] = (s1_a[j] & s1_b[i]) ^ (s1_sgn & ((i == W - 1) != (j == W - 1)));
            end
        end
        if (s1_sgn) begin
            pp[0][W]     = 1'b1;
            pp[0][2*W-1] = 1'b1;
        end
    end

    // The CSA tree is split over two register slices (s3a/s3b), giving four edges from transfer to out_valid.
    assign tree_a           = csa_reduce(s2_pp, W, LV_A);
    assign {carry_d, sum_d} = csa_pair(s3a_rows, N_MID, LV_B);
    assign prod             = s3b_sum + s3b_carry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sgn    <= 1'b0;
            s1_tag    <= '0;
            s2_v      <= 1'b0;
            s2_pp     <= '0;
            s2_tag    <= '0;
            s3a_v     <= 1'b0;
            s3a_rows  <= '0;
            s3a_tag   <= '0;
            s3b_v     <= 1'b0;
            s3b_sum   <= '0;
            s3b_carry <= '0;
            s3b_tag   <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            s1_v      <= in_valid;
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_sgn    <= in_sgn;
            s1_tag    <= in_tag;
            s2_v      <= s1_v;
            s2_pp     <= pp;
            s2_tag    <= s1_tag;
            s3a_v     <= s2_v;
            s3a_rows  <= tree_a;
            s3a_tag   <= s2_tag;
            s3b_v     <= s3a_v;
            s3b_sum   <= sum_d;
            s3b_carry <= carry_d;
            s3b_tag   <= s3a_tag;
            out_valid <= s3b_v;
            if (s3b_v) begin
                out_p   <= res;
                out_tag <= s3b_tag;
            end
        end
    end

`ifdef PIPE_MULT_ACC_EN
    logic           s1_acc, s2_acc, s3a_acc, s3b_acc;
    logic [2*W-1:0] acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_acc  <= 1'b0;
            s2_acc  <= 1'b0;
            s3a_acc <= 1'b0;
            s3b_acc <= 1'b0;
            acc_q   <= '0;
        end else if (adv) begin
            s1_acc  <= in_acc;
            s2_acc  <= s1_acc;
            s3a_acc <= s2_acc;
            s3b_acc <= s3a_acc;
            if (s3b_v) acc_q <= res;
        end
    end

    assign res = s3b_acc ? prod + acc_q : prod;
`else
    assign res = prod;
`endif

endmodule

// File: tb/tb_pipe_mult_csa.sv
// Self-checking bench for pipe_mult_csa: directed vectors at W=8 and W=16, a scoreboarded
// random stream with stalls, mid-flight reset, and the accumulate sequence when compiled in.
module tb_pipe_mult_csa;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        v8 = 1'b0, sgn8 = 1'b0, ordy8 = 1'b0;
    logic        rdy8, ov8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  tag8 = '0, ot8;
    logic [15:0] p8;

    logic        v16 = 1'b0, sgn16 = 1'b0, ordy16 = 1'b1;
    logic        rdy16, ov16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  tag16 = '0, ot16;
    logic [31:0] p16;

`ifdef PIPE_MULT_ACC_EN
    logic acc8 = 1'b0, acc16 = 1'b0;
`endif

    pipe_mult_csa #(.W(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8), .in_sgn(sgn8), .in_tag(tag8),
`ifdef PIPE_MULT_ACC_EN
        .in_acc(acc8),
`endif
        .out_valid(ov8), .out_ready(ordy8), .out_p(p8), .out_tag(ot8)
    );

    pipe_mult_csa #(.W(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(v16), .in_ready(rdy16), .in_a(a16), .in_b(b16), .in_sgn(sgn16), .in_tag(tag16),
`ifdef PIPE_MULT_ACC_EN
        .in_acc(acc16),
`endif
        .out_valid(ov16), .out_ready(ordy16), .out_p(p16), .out_tag(ot16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] t);
        v8 = 1'b1; a8 = a; b8 = b; sgn8 = s; tag8 = t;
    endtask

    task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [3:0] t);
        v16 = 1'b1; a16 = a; b16 = b; sgn16 = s; tag16 = t;
    endtask

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int x, y;
        x = s ? {{24{a[7]}}, a} : {24'b0, a};
        y = s ? {{24{b[7]}}, b} : {24'b0, b};
        return 16'(x * y);
    endfunction

    typedef struct packed {
        logic [15:0] p;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];

    task automatic run_stream(input int n_txn);
        int          gen = 0, recv = 0, cyc = 0, stall_cnt = 0;
        bit          have = 0, stall_done = 0, in_stall = 0, held = 0;
        logic [15:0] held_p = '0;
        logic [3:0]  held_tag = '0;
        exp_t        e;
        while (recv < n_txn && cyc < 8000) begin
            in_stall = !stall_done && gen >= n_txn / 2;
            if (!have && gen < n_txn && (in_stall || $urandom_range(0, 9) < 7)) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                sgn8 = 1'($urandom_range(0, 1));
                tag8 = 4'($urandom);
                have = 1;
                gen++;
            end
            v8    = have;
            ordy8 = in_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (held) begin
                check("stall_valid", ov8, 1);
                check("stall_p", p8, held_p);
                check("stall_tag", ot8, held_tag);
            end
            if (in_stall && stall_cnt >= 6) check("stall_in_ready", rdy8, 0);
            if (ov8 && ordy8) begin
                check("stream_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("stream_p", p8, e.p);
                    check("stream_tag", ot8, e.tag);
                end
                recv++;
            end
            if (have && rdy8) begin
                e.p   = model8(a8, b8, sgn8);
                e.tag = tag8;
                sb.push_back(e);
                have = 0;
            end
            held     = ov8 && !ordy8;
            held_p   = p8;
            held_tag = ot8;
            if (in_stall) begin
                stall_cnt++;
                if (stall_cnt == 16) stall_done = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        v8    = 1'b0;
        ordy8 = 1'b1;
        check("stream_recv", recv, n_txn);
        check("stream_left", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;

        // Reset state, with out_ready low so in_ready reflects !out_valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", ov8, 0);
        check("rst_in_ready", rdy8, 1);
        check("rst_out_p", p8, 0);
        check("rst_out_tag", ot8, 0);
        check("rst_out_valid16", ov16, 0);
        check("rst_in_ready16", rdy16, 1);
        @(negedge clk);
        rst   = 1'b1;
        ordy8 = 1'b1;

        // Unsigned 0xFF x 0xFF, exact 4-edge latency.
        drive8(8'hFF, 8'hFF, 1'b0, 4'd3);
        tick();
        v8 = 1'b0;
        tick(); check("lat_e1_valid", ov8, 0);
        tick(); check("lat_e2_valid", ov8, 0);
        tick(); check("lat_e3_valid", ov8, 0);
        tick();
        check("lat_e4_valid", ov8, 1);
        check("ff_ff_p", p8, 16'hFE01);
        check("ff_ff_tag", ot8, 3);

        // Signed back-to-back.
        drive8(8'h80, 8'h80, 1'b1, 4'd1); tick();
        drive8(8'hFF, 8'h7F, 1'b1, 4'd2); tick();
        drive8(8'h80, 8'h7F, 1'b1, 4'd3); tick();
        v8 = 1'b0;
        tick(); check("sgn_pre_valid", ov8, 0);
        tick(); check("sgn0_valid", ov8, 1); check("sgn0_p", p8, 16'h4000); check("sgn0_tag", ot8, 1);
        tick(); check("sgn1_valid", ov8, 1); check("sgn1_p", p8, 16'hFF81); check("sgn1_tag", ot8, 2);
        tick(); check("sgn2_valid", ov8, 1); check("sgn2_p", p8, 16'hC080); check("sgn2_tag", ot8, 3);
        tick(); check("sgn_post_valid", ov8, 0);

        // W=16 extremes.
        drive16(16'hFFFF, 16'hFFFF, 1'b0, 4'd5); tick();
        drive16(16'hFFFF, 16'hFFFF, 1'b1, 4'd6); tick();
        v16 = 1'b0;
        tick();
        tick(); check("w16_pre_valid", ov16, 0);
        tick(); check("w16_u_valid", ov16, 1); check("w16_u_p", p16, 32'hFFFE0001); check("w16_u_tag", ot16, 5);
        tick(); check("w16_s_valid", ov16, 1); check("w16_s_p", p16, 32'h00000001); check("w16_s_tag", ot16, 6);

        // Random stream with gaps, back-pressure and one long full-pipe stall.
        tick();
        run_stream(200);
        tick();

        // Reset with three transactions in flight.
        drive8(8'd11, 8'd12, 1'b0, 4'd1); tick();
        drive8(8'd13, 8'd14, 1'b0, 4'd2); tick();
        drive8(8'd15, 8'd16, 1'b0, 4'd3); tick();
        v8 = 1'b0;
        #2;
        rst   = 1'b0;
        ordy8 = 1'b0;
        #1;
        check("mid_rst_valid", ov8, 0);
        check("mid_rst_in_ready", rdy8, 1);
        check("mid_rst_p", p8, 0);
        @(negedge clk);
        rst   = 1'b1;
        ordy8 = 1'b1;
        seen  = 0;
        repeat (6) begin
            tick();
            if (ov8) seen = 1;
        end
        check("rst_flush", seen, 0);
        drive8(8'd5, 8'd7, 1'b0, 4'd9);
        tick();
        v8 = 1'b0;
        tick();
        tick();
        tick(); check("post_rst_pre_valid", ov8, 0);
        tick(); check("post_rst_valid", ov8, 1); check("post_rst_p", p8, 35); check("post_rst_tag", ot8, 9);

`ifdef PIPE_MULT_ACC_EN
        acc8 = 1'b0; drive8(8'd3, 8'd4, 1'b0, 4'd1); tick();
        acc8 = 1'b1; drive8(8'd5, 8'd6, 1'b0, 4'd2); tick();
        acc8 = 1'b1; drive8(8'd2, 8'd2, 1'b0, 4'd3); tick();
        acc8 = 1'b0; drive8(8'd1, 8'd1, 1'b0, 4'd4); tick();
        v8 = 1'b0;
        tick(); check("acc0_p", p8, 12); check("acc0_valid", ov8, 1);
        tick(); check("acc1_p", p8, 42);
        tick(); check("acc2_p", p8, 46);
        tick(); check("acc3_p", p8, 1); check("acc3_tag", ot8, 4);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
